// File: rtl/uart_pkg.sv
// Shared UART constants (data width, baud timing) and the transmit FSM state encoding.
// The PARITY state and parity helper only matter when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int CLK_HZ      = 50_000_000;
    localparam int BAUD        = 9600;
    localparam int BAUD_DIV    = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd5
    } tx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte-source handshake bundle between the on-chip producers and the UART transmit scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    import uart_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Baud rate generator: one-cycle txclk_en strobe every DIV clk_50m cycles (9600 baud by default).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int  DIV   = BAUD_DIV,
    localparam int CNT_W = $clog2(DIV)
) (
    input  logic clk_50m,
    input  logic rst_n,
    output logic txclk_en
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            txclk_en <= 1'b0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt      <= '0;
            txclk_en <= 1'b1;
        end else begin
            cnt      <= cnt + 1'b1;
            txclk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request searching upward from ptr+1 with wrap.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // NOTE: every output is given a default before the search so no path leaves it unassigned (no latch).
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_idx;
        logic            found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = ID_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1/8N2 UART tx line among NUM_REQ byte sources.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 (8E1/8E2).
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  STOP_BITS = 1,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    input  logic               txclk_en,
    uart_tx_scheduler_if.slave req_if,
    output logic               tx,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id
);

    localparam int BIT_CNT_W = $clog2(UART_DATA_W);

    tx_state_t              state, state_d;
    logic                   tx_d, busy_d;
    logic [ID_W-1:0]        grant_id_d, ptr, ptr_d;
    logic [UART_DATA_W-1:0] shreg, shreg_d, win_byte;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic                   stop_cnt, stop_cnt_d;
    logic [NUM_REQ-1:0]     win_oh;
    logic [ID_W-1:0]        win_idx;
    logic                   accept;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_if.req_valid),
        .ptr       (ptr),
        .grant     (win_oh),
        .grant_idx (win_idx)
    );

    // Ready is gated by rst_n so nothing is offered while reset is asserted.
    assign req_if.req_ready = (rst_n && state == ST_IDLE) ? win_oh : '0;
    assign accept           = (state == ST_IDLE) && (|win_oh);

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_byte = req_if.req_data[UART_DATA_W*i +: UART_DATA_W];
        end
    end

    always_comb begin
        state_d    = state;
        tx_d       = tx;
        busy_d     = busy;
        grant_id_d = grant_id;
        ptr_d      = ptr;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        stop_cnt_d = stop_cnt;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state)
            ST_IDLE: if (accept) begin
                shreg_d    = win_byte;
                grant_id_d = win_idx;
                ptr_d      = win_idx;
                busy_d     = 1'b1;
                state_d    = ST_SYNC;
`ifdef UART_TX_PARITY_EN
                par_d      = even_parity(win_byte);
`endif
            end
            // A tick coincident with the accept is ignored: SYNC only sees ticks from the next cycle on.
            ST_SYNC: if (txclk_en) begin
                tx_d    = 1'b0;
                state_d = ST_START;
            end
            ST_START: if (txclk_en) begin
                tx_d      = shreg[0];
                shreg_d   = shreg >> 1;
                bit_cnt_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: if (txclk_en) begin
                if (bit_cnt == BIT_CNT_W'(UART_DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                    tx_d       = par_q;
                    state_d    = ST_PARITY;
`else
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
`endif
                end else begin
                    tx_d      = shreg[0];
                    shreg_d   = shreg >> 1;
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (txclk_en) begin
                tx_d       = 1'b1;
                stop_cnt_d = 1'b0;
                state_d    = ST_STOP;
            end
`endif
            ST_STOP: if (txclk_en) begin
                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            grant_id <= '0;
            ptr      <= ID_W'(NUM_REQ - 1);
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            tx       <= tx_d;
            busy     <= busy_d;
            grant_id <= grant_id_d;
            ptr      <= ptr_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            stop_cnt <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration order, frame contents sampled mid-bit, bit timing, reset.
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int FAST_DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic            clk_50m = 1'b0;
    logic            rst_n;
    logic            use_real;
    logic            en_fast, en_real, txclk_en;
    logic            tx, busy;
    logic [ID_W-1:0] grant_id;
    int              tests_run    = 0;
    int              tests_failed = 0;
    int              div_now      = FAST_DIV;

    always #10 clk_50m = ~clk_50m;

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_baud_gen #(.DIV(FAST_DIV)) u_fast (.clk_50m(clk_50m), .rst_n(rst_n), .txclk_en(en_fast));
    uart_baud_gen u_real (.clk_50m(clk_50m), .rst_n(rst_n), .txclk_en(en_real));

    // Short frames for most scenarios; the real 9600-baud strobe for the timing scenario.
    assign txclk_en = use_real ? en_real : en_fast;

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .STOP_BITS(1)) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .txclk_en (txclk_en),
        .req_if   (bus),
        .tx       (tx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    function automatic logic [11:0] exp_frame(input logic [7:0] d);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    task automatic wait_start(output bit ok, output logic en_edge);
        logic en_prev;
        ok      = 1'b0;
        en_edge = 1'b0;
        en_prev = txclk_en;
        for (int i = 0; i < 4 * div_now; i++) begin
            @(negedge clk_50m);
            if (tx === 1'b0) begin
                ok      = 1'b1;
                en_edge = en_prev;
                break;
            end
            en_prev = txclk_en;
        end
    endtask

    task automatic capture_frame(input string name, input logic [7:0] d, input logic [ID_W-1:0] id,
                                 input logic [NUM_REQ-1:0] valid_after, output logic [11:0] obs);
        bit          ok;
        bit          fell;
        logic        en_edge;
        logic [11:0] exp_f;
        obs   = '1;
        exp_f = exp_frame(d);
        wait_start(ok, en_edge);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s_start: tx stayed %b, required start bit 0", name, tx);
            return;
        end
        repeat (div_now / 2) @(negedge clk_50m);
        tests_run++;
        if (grant_id !== id) begin
            tests_failed++;
            $display("FAIL %s_grant_id: got %0d, required %0d", name, grant_id, id);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_busy: got %b, required 1", name, busy);
        end
        bus.req_valid = valid_after;
        for (int b = 0; b < FRAME_BITS; b++) begin
            if (b != 0) repeat (div_now) @(negedge clk_50m);
            obs[b] = tx;
        end
        tests_run++;
        if (obs !== exp_f) begin
            tests_failed++;
            $display("FAIL %s_frame: got %b, required %b", name, obs, exp_f);
        end
        fell = 1'b0;
        for (int i = 0; i < div_now + 4; i++) begin
            @(negedge clk_50m);
            if (busy === 1'b0) begin
                fell = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!fell) begin
            tests_failed++;
            $display("FAIL %s_busy_fall: busy still %b after last stop bit", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        use_real      = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        repeat (3) @(negedge clk_50m);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b, required 1", tx); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests_run++;
        if (bus.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b, required 0000", bus.req_ready);
        end
        tests_run++;
        if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
        bus.req_valid = '0;
        rst_n         = 1'b1;
        @(negedge clk_50m);
    endtask

    task automatic test_contention();
        logic [11:0] obs;
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_valid = 4'hF;
        for (int f = 0; f < 5; f++) begin
            capture_frame($sformatf("contention%0d", f), 8'h10 + 8'(f % 4), ID_W'(f % 4),
                          (f == 4) ? 4'h0 : 4'hF, obs);
            if (f < 4) begin
                @(negedge clk_50m);
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL back_to_back%0d: busy %b one cycle after fall, required 1", f, busy);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [11:0] obs;
        @(negedge clk_50m);
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid     = 4'b0001;
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_ready: got %b, required 0001", bus.req_ready);
        end
        @(negedge clk_50m);
        tests_run++;
        if (bus.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_ready_drop: got %b, required 0000", bus.req_ready);
        end
        bus.req_valid     = '0;
        bus.req_data[7:0] = 8'hFF;
        capture_frame("single", 8'hA5, 2'd0, 4'b0000, obs);
`ifndef UART_TX_PARITY_EN
        tests_run++;
        if (obs[9:0] !== 10'b11_0100_1010) begin
            tests_failed++;
            $display("FAIL single_literal: got %b, required 1101001010", obs[9:0]);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [11:0] obs;
        bus.req_data  = {8'h5C, 8'h12, 8'h11, 8'hC3};
        bus.req_valid = 4'b1000;
        capture_frame("wrap_a", 8'h5C, 2'd3, 4'b1000, obs);
        capture_frame("wrap_b", 8'h5C, 2'd3, 4'b1001, obs);
        capture_frame("wrap_c", 8'hC3, 2'd0, 4'b1001, obs);
        capture_frame("wrap_d", 8'h5C, 2'd3, 4'b0000, obs);
    endtask

    task automatic test_reset_mid();
        bit          ok;
        logic        en_edge;
        logic [11:0] obs;
        bus.req_data[15:8] = 8'h4A;
        bus.req_valid      = 4'b0010;
        wait_start(ok, en_edge);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL reset_mid_start: tx stayed %b, required 0", tx); end
        repeat (div_now / 2 + 5 * div_now) @(negedge clk_50m);
        tests_run++;
        if (tx !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_bit4: got %b, required 0", tx); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_tx: got %b, required 1", tx); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_busy: got %b, required 0", busy); end
        tests_run++;
        if (bus.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mid_ready: got %b, required 0000", bus.req_ready);
        end
        tests_run++;
        if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_mid_grant_id: got %0d, required 0", grant_id); end
        @(negedge clk_50m);
        rst_n = 1'b1;
        capture_frame("post_reset", 8'h4A, 2'd1, 4'b0000, obs);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [11:0] obs;
        bus.req_data[7:0] = 8'h07;
        bus.req_valid     = 4'b0001;
        capture_frame("parity_07", 8'h07, 2'd0, 4'b0000, obs);
        tests_run++;
        if (obs[9] !== 1'b1) begin tests_failed++; $display("FAIL parity_07_bit: got %b, required 1", obs[9]); end
        bus.req_data[7:0] = 8'h03;
        bus.req_valid     = 4'b0001;
        capture_frame("parity_03", 8'h03, 2'd0, 4'b0000, obs);
        tests_run++;
        if (obs[9] !== 1'b0) begin tests_failed++; $display("FAIL parity_03_bit: got %b, required 0", obs[9]); end
    endtask
`endif

    task automatic test_timing();
        bit   ok;
        logic en_edge;
        logic lvl;
        int   w;
        @(negedge clk_50m);
        use_real            = 1'b1;
        div_now             = 5208;
        bus.req_data[23:16] = 8'hA5;
        bus.req_valid       = 4'b0100;
        wait_start(ok, en_edge);
        bus.req_valid = '0;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL timing_start: tx stayed %b, required 0", tx); end
        tests_run++;
        if (en_edge !== 1'b1) begin
            tests_failed++;
            $display("FAIL timing_start_on_tick: txclk_en at start edge %b, required 1", en_edge);
        end
        // Start bit (0), bit0 (1), bit1 (0) of 8'hA5, each measured edge to edge.
        for (int s = 0; s < 3; s++) begin
            lvl = (s == 1);
            w   = 0;
            do begin
                @(negedge clk_50m);
                w++;
            end while (tx === lvl && w < 2 * 5208);
            tests_run++;
            if (w != 5208) begin
                tests_failed++;
                $display("FAIL timing_width%0d: got %0d cycles, required 5208", s, w);
            end
        end
        rst_n = 1'b0;
        @(negedge clk_50m);
        rst_n    = 1'b1;
        use_real = 1'b0;
        div_now  = FAST_DIV;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_wrap();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_timing();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
